// File: rtl/multiply_accum_chan.sv
// Multi-channel unsigned multiply-accumulate with first/last framing; optional saturation via MULTIPLY_ACCUM_CHAN_SAT_EN.
// Latency: 3 cycles from accepted sample to out_valid; one sample per cycle, any channel order.
// No backpressure: the consumer must accept every out_valid pulse.
module multiply_accum_chan #(
    parameter int WIDTH    = 8,
    parameter int GUARD    = 4,
    parameter int CHANNELS = 4,
    localparam int ACCW    = 2*WIDTH + GUARD,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [CW-1:0]    in_chan,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    output logic [CW-1:0]    out_chan,
    output logic [ACCW-1:0]  RES,
    output logic             out_ovf
);

    localparam int PW = 2*WIDTH;
    localparam logic [CW:0] NCH = (CW+1)'(CHANNELS);
`ifdef MULTIPLY_ACCUM_CHAN_SAT_EN
    localparam int SW = ACCW + 1;
`else
    localparam int SW = ACCW;
`endif

    logic             s1_valid, s1_first, s1_last;
    logic [WIDTH-1:0] s1_a, s1_b;
    logic [CW-1:0]    s1_chan;

    logic             s2_valid, s2_first, s2_last;
    logic [PW-1:0]    s2_mult;
    logic [CW-1:0]    s2_chan;

    logic [ACCW-1:0]  acc [CHANNELS];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_chan  <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a     <= A;
                s1_b     <= B;
                s1_chan  <= in_chan;
                s1_first <= in_first;
                s1_last  <= in_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_mult  <= '0;
            s2_chan  <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_mult  <= PW'(s1_a) * PW'(s1_b);
                s2_chan  <= s1_chan;
                s2_first <= s1_first;
                s2_last  <= s1_last;
            end
        end
    end

    // Out-of-range channels still flow down the pipe but never touch state.
    logic            in_range;
    logic [CW-1:0]   sel;
    logic [ACCW-1:0] acc_base, acc_new;
    logic [SW-1:0]   sum;
`ifdef MULTIPLY_ACCUM_CHAN_SAT_EN
    logic            ovf [CHANNELS];
    logic            ovf_new;
`endif

    always_comb begin
        in_range = ({1'b0, s2_chan} < NCH);
        sel      = in_range ? s2_chan : '0;
        acc_base = s2_first ? '0 : acc[sel];
        sum      = SW'(acc_base) + SW'(s2_mult);
`ifdef MULTIPLY_ACCUM_CHAN_SAT_EN
        acc_new  = sum[ACCW] ? '1 : sum[ACCW-1:0];
        ovf_new  = (s2_first ? 1'b0 : ovf[sel]) | sum[ACCW];
`else
        acc_new  = sum;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= '0;
`ifdef MULTIPLY_ACCUM_CHAN_SAT_EN
                ovf[i] <= 1'b0;
`endif
            end
            out_valid <= 1'b0;
            out_chan  <= '0;
            RES       <= '0;
`ifdef MULTIPLY_ACCUM_CHAN_SAT_EN
            out_ovf   <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
            if (s2_valid && in_range) begin
                acc[sel] <= acc_new;
`ifdef MULTIPLY_ACCUM_CHAN_SAT_EN
                ovf[sel] <= ovf_new;
`endif
                if (s2_last) begin
                    out_valid <= 1'b1;
                    out_chan  <= sel;
                    RES       <= acc_new;
`ifdef MULTIPLY_ACCUM_CHAN_SAT_EN
                    out_ovf   <= ovf_new;
`endif
                end
            end
        end
    end

`ifndef MULTIPLY_ACCUM_CHAN_SAT_EN
    assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_multiply_accum_chan.sv
// Bench for multiply_accum_chan: directed framing scenarios plus random traffic against an arithmetic reference model.
module tb_multiply_accum_chan;

    localparam int CH   = 4;
    localparam int ACCW = 20;
    localparam longint MAXV = (64'd1 << ACCW) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
    logic [7:0]  a = '0, b = '0;
    logic [1:0]  in_chan = '0;

    logic        out_valid, out_ovf, u3_out_valid, u3_out_ovf;
    logic [1:0]  out_chan, u3_out_chan;
    logic [19:0] res, u3_res;

    multiply_accum_chan #(.WIDTH(8), .GUARD(4), .CHANNELS(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b), .in_chan(in_chan),
        .in_first(in_first), .in_last(in_last), .out_valid(out_valid),
        .out_chan(out_chan), .RES(res), .out_ovf(out_ovf));

    multiply_accum_chan #(.WIDTH(8), .GUARD(4), .CHANNELS(3)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b), .in_chan(in_chan),
        .in_first(in_first), .in_last(in_last), .out_valid(u3_out_valid),
        .out_chan(u3_out_chan), .RES(u3_res), .out_ovf(u3_out_ovf));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [19:0] res;
        logic [1:0]  ch;
        logic        ovf;
        logic [31:0] cyc;
    } res_t;

    res_t obs[$], exp_q[$], obs3[$];
    res_t o, e;
    int   cyc = 0;
    int   checks = 0, errors = 0;
    longint macc [CH];
    bit     movf [CH];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid)    obs.push_back('{res, out_chan, out_ovf, cyc});
        if (u3_out_valid) obs3.push_back('{u3_res, u3_out_chan, u3_out_ovf, cyc});
    end

    task automatic model_clear();
        for (int i = 0; i < CH; i++) begin
            macc[i] = 0;
            movf[i] = 1'b0;
        end
    endtask

    // Drive one cycle of stimulus and advance the reference model for it.
    task automatic send(input bit v, input int av, input int bv, input int ch, input bit f, input bit l);
        longint s;
        bit     ov;
        @(negedge clk);
        in_valid = v; a = av[7:0]; b = bv[7:0]; in_chan = ch[1:0]; in_first = f; in_last = l;
        if (v && ch < CH) begin
            s = (f ? 64'd0 : macc[ch]) + longint'(av) * longint'(bv);
`ifdef MULTIPLY_ACCUM_CHAN_SAT_EN
            ov = f ? 1'b0 : movf[ch];
            if (s > MAXV) begin
                s  = MAXV;
                ov = 1'b1;
            end
`else
            ov = 1'b0;
            s  = s % (MAXV + 1);
`endif
            macc[ch] = s;
            movf[ch] = ov;
            if (l) exp_q.push_back('{s[19:0], ch[1:0], ov, 32'(cyc + 3)});
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_chan !== 2'd0) begin errors++; $display("FAIL reset_out_chan: got %0d want 0", out_chan); end
        checks++; if (res !== 20'd0) begin errors++; $display("FAIL reset_res: got %0d want 0", res); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf: got %b want 0", out_ovf); end
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_defaults();
        send(1, 3, 4, 0, 1, 0);
        send(1, 5, 6, 0, 0, 0);
        send(1, 7, 8, 0, 0, 1);
        idle(6);
        checks++; if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL defaults_count: got %0d want %0d", obs.size(), exp_q.size()); end
        while (obs.size() > 0 && exp_q.size() > 0) begin
            o = obs.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL defaults_result: got res=%0d ch=%0d ovf=%0d cyc=%0d want res=%0d ch=%0d ovf=%0d cyc=%0d", o.res, o.ch, o.ovf, o.cyc, e.res, e.ch, e.ovf, e.cyc); end
        end
        obs.delete(); exp_q.delete();
        checks++; if (res !== 20'd98) begin errors++; $display("FAIL defaults_hold: got %0d want 98", res); end
    endtask

    task automatic test_interleave();
        send(1, 10, 10, 1, 1, 0);
        send(1, 2, 2, 2, 1, 1);
        send(1, 1, 1, 1, 0, 1);
        send(1, 255, 255, 3, 1, 1);
        idle(6);
        checks++; if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL interleave_count: got %0d want %0d", obs.size(), exp_q.size()); end
        while (obs.size() > 0 && exp_q.size() > 0) begin
            o = obs.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL interleave_result: got res=%0d ch=%0d ovf=%0d cyc=%0d want res=%0d ch=%0d ovf=%0d cyc=%0d", o.res, o.ch, o.ovf, o.cyc, e.res, e.ch, e.ovf, e.cyc); end
        end
        obs.delete(); exp_q.delete();
        checks++; if (res !== 20'd65025 || out_chan !== 2'd3) begin errors++; $display("FAIL interleave_last: got res=%0d ch=%0d want res=65025 ch=3", res, out_chan); end
    endtask

    task automatic test_bubbles();
        send(1, 200, 200, 0, 1, 0);
        send(0, 0, 0, 0, 0, 0);
        send(1, 1, 1, 0, 0, 0);
        send(0, 9, 9, 0, 0, 1);
        send(1, 2, 3, 0, 0, 1);
        idle(6);
        checks++; if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL bubbles_count: got %0d want %0d", obs.size(), exp_q.size()); end
        while (obs.size() > 0 && exp_q.size() > 0) begin
            o = obs.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL bubbles_result: got res=%0d ch=%0d ovf=%0d cyc=%0d want res=%0d ch=%0d ovf=%0d cyc=%0d", o.res, o.ch, o.ovf, o.cyc, e.res, e.ch, e.ovf, e.cyc); end
        end
        obs.delete(); exp_q.delete();
        checks++; if (res !== 20'd40007) begin errors++; $display("FAIL bubbles_res: got %0d want 40007", res); end
    endtask

    task automatic test_overflow();
        logic [19:0] want_res;
        logic        want_ovf;
`ifdef MULTIPLY_ACCUM_CHAN_SAT_EN
        want_res = 20'd1048575; want_ovf = 1'b1;
`else
        want_res = 20'd56849;   want_ovf = 1'b0;
`endif
        for (int i = 1; i <= 17; i++) send(1, 255, 255, 0, i == 1, i == 17);
        idle(5);
        checks++; if (res !== want_res || out_ovf !== want_ovf) begin errors++; $display("FAIL overflow_17: got res=%0d ovf=%b want res=%0d ovf=%b", res, out_ovf, want_res, want_ovf); end
        send(1, 1, 1, 0, 1, 1);
        idle(6);
        checks++; if (res !== 20'd1 || out_ovf !== 1'b0) begin errors++; $display("FAIL overflow_restart: got res=%0d ovf=%b want res=1 ovf=0", res, out_ovf); end
        checks++; if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL overflow_count: got %0d want %0d", obs.size(), exp_q.size()); end
        while (obs.size() > 0 && exp_q.size() > 0) begin
            o = obs.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL overflow_result: got res=%0d ch=%0d ovf=%0d cyc=%0d want res=%0d ch=%0d ovf=%0d cyc=%0d", o.res, o.ch, o.ovf, o.cyc, e.res, e.ch, e.ovf, e.cyc); end
        end
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_reset_midframe();
        send(1, 9, 9, 0, 1, 0);
        send(1, 9, 9, 0, 0, 0);
        do_reset(1);
        checks++; if (res !== 20'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL midrst_cleared: got res=%0d vld=%b want res=0 vld=0", res, out_valid); end
        send(1, 1, 2, 0, 1, 1);
        idle(6);
        checks++; if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL midrst_count: got %0d want %0d", obs.size(), exp_q.size()); end
        while (obs.size() > 0 && exp_q.size() > 0) begin
            o = obs.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL midrst_result: got res=%0d ch=%0d ovf=%0d cyc=%0d want res=%0d ch=%0d ovf=%0d cyc=%0d", o.res, o.ch, o.ovf, o.cyc, e.res, e.ch, e.ovf, e.cyc); end
        end
        obs.delete(); exp_q.delete();
        checks++; if (res !== 20'd2 || out_chan !== 2'd0) begin errors++; $display("FAIL midrst_res: got res=%0d ch=%0d want res=2 ch=0", res, out_chan); end
    endtask

    task automatic test_chan_oob();
        do_reset(2);
        obs.delete(); obs3.delete();
        send(1, 5, 5, 3, 1, 1);
        send(1, 1, 1, 2, 0, 1);
        idle(6);
        checks++; if (obs3.size() !== 1) begin errors++; $display("FAIL oob_count: got %0d want 1", obs3.size()); end
        if (obs3.size() >= 1) begin
            checks++; if (obs3[0].res !== 20'd1 || obs3[0].ch !== 2'd2) begin errors++; $display("FAIL oob_result: got res=%0d ch=%0d want res=1 ch=2", obs3[0].res, obs3[0].ch); end
        end
        checks++; if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL oob_main_count: got %0d want %0d", obs.size(), exp_q.size()); end
        while (obs.size() > 0 && exp_q.size() > 0) begin
            o = obs.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL oob_main_result: got res=%0d ch=%0d ovf=%0d cyc=%0d want res=%0d ch=%0d ovf=%0d cyc=%0d", o.res, o.ch, o.ovf, o.cyc, e.res, e.ch, e.ovf, e.cyc); end
        end
        obs.delete(); exp_q.delete(); obs3.delete();
    endtask

    task automatic test_random();
        do_reset(2);
        obs.delete();
        for (int i = 0; i < 400; i++) begin
            send($urandom_range(4, 0) != 0, $urandom_range(255, 0), $urandom_range(255, 0),
                 $urandom_range(CH - 1, 0), $urandom_range(3, 0) == 0, $urandom_range(3, 0) == 0);
        end
        idle(6);
        checks++; if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL random_count: got %0d want %0d", obs.size(), exp_q.size()); end
        while (obs.size() > 0 && exp_q.size() > 0) begin
            o = obs.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL random_result: got res=%0d ch=%0d ovf=%0d cyc=%0d want res=%0d ch=%0d ovf=%0d cyc=%0d", o.res, o.ch, o.ovf, o.cyc, e.res, e.ch, e.ovf, e.cyc); end
        end
        obs.delete(); exp_q.delete(); obs3.delete();
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_interleave();
        test_bubbles();
        test_overflow();
        test_reset_midframe();
        test_chan_oob();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
